prio_encoder_q: RTL and testbench
=================================

PRIO_ENCODER_Q -- requirements
Module: prio_encoder_q

Interface
REQ-001 Parameter N, default 8: number of request inputs, legal range 2..64.
REQ-002 Parameter W, default $clog2(N) (3): width of the encoded output.
REQ-003 Parameter MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 w  input  N  request vector; bit i high for one or more cycles posts a request for index i.
REQ-007 y  output  W  encoded index of the issued request (registered).
REQ-008 y_valid  output  1  y holds a valid issued index (registered).
REQ-009 y_ready  input  1  consumer accepts y when y_valid && y_ready.
REQ-010 busy  output  1  high when pend != 0 or y_valid = 1.

Function
REQ-011 The block SHALL hold an internal N-bit sticky vector pend; a cycle with w[i]=1 sets pend[i].
REQ-012 The block SHALL perform a load when (!y_valid || y_ready) && pend != 0; the load selects index s from the current pend.
REQ-013 On load: y <= s, y_valid <= 1, and pend[s] cleared in the same edge.
REQ-014 pend_next SHALL be (pend & ~onehot(s) when load) | w; a w[s]=1 in the load cycle wins and leaves pend[s]=1, so the request is issued again later.
REQ-015 No load with y_valid && y_ready: y_valid <= 0, y keeps its last value.
REQ-016 y_valid && !y_ready: y and y_valid SHALL hold stable; new w bits accumulate in pend only.
REQ-017 Latency: w[i] sampled at edge t, pend[i] set after t, y_valid=1 with y=i after edge t+1 if output is free and i is selected.
REQ-018 Throughput: one index per cycle while y_ready=1 and pend != 0.
REQ-019 MODE=0: s = highest set index of pend.
REQ-020 MODE=1: W-bit pointer ptr; s = first set index of pend searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-021 MODE=1: on load, ptr <= s+1, wrapping to 0 when s = N-1; ptr unchanged otherwise.
REQ-022 MODE=0: ptr SHALL be unused and held at 0.
REQ-023 Request to an index already pending SHALL merge; one issue per pend bit set.
REQ-024 busy SHALL be combinational from registered state only.

Reset
REQ-025 On rst_n low, immediately and independent of clk: pend=0, y=0, y_valid=0, ptr=0, busy=0.
REQ-026 Reset asserted mid-operation SHALL discard all pending and held requests; first load after release follows REQ-017.
REQ-027 w sampled while rst_n low SHALL be ignored.

Verification (N=8)
REQ-028 Reset: pend=0x3C, y_valid=1, drop rst_n between edges -> y=0, y_valid=0, busy=0 before next edge; no issue after release with w=0.
REQ-029 MODE=0: w=0x24 one cycle, y_ready=1 -> y=5 valid 2 edges later, then y=2 next cycle, then y_valid=0, busy=0.
REQ-030 MODE=0 backpressure: y_ready=0, w=0x01 cycle 1, w=0x80 cycle 2 -> y=0 valid and held stable; raise y_ready -> next y=7, then y_valid=0.
REQ-031 MODE=1: w=0xFF one cycle, y_ready=1 -> y=0,1,2,...,7 on consecutive cycles, then y_valid=0, ptr=0.
REQ-032 MODE=1 wrap: after issue of 6 (ptr=7), w=0x41 -> y=0, then y=6.
REQ-033 Re-request: w[3]=1 in the load cycle of index 3, y_ready=1 -> index 3 issued twice, on consecutive cycles.

Source files
------------

// File: rtl/prio_encoder_q_if.sv
// Request/issue bus for prio_encoder_q: request vector in, encoded index out with
// valid/ready handshake, plus a busy status line.
interface prio_encoder_q_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
);
  logic [N-1:0] w;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;
  logic         busy;

  // Requester/consumer side.
  modport master (
    output w,
    output y_ready,
    input  y,
    input  y_valid,
    input  busy
  );

  // Encoder side.
  modport slave (
    input  w,
    input  y_ready,
    output y,
    output y_valid,
    output busy
  );
endinterface

// File: rtl/prio_encoder_q.sv
// Queued priority encoder: requests stick in a pending vector and are issued one
// index per cycle, either highest-index-first (MODE=0) or round-robin (MODE=1).
module prio_encoder_q #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = $clog2(N),
  parameter int unsigned MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_encoder_q_if.slave   bus
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         y_valid_q, y_valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] sel;
  logic         found;
  int unsigned  pos;
  logic [W-1:0] idx;
  logic         load;
  logic [N-1:0] sel_onehot;

  // Choose the index to issue from the current pending vector.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    if (MODE == 0) begin
      // Later iterations overwrite, so the highest set index wins.
      for (int unsigned i = 0; i < N; i++) begin
        if (pend_q[i]) sel = W'(i);
      end
    end else begin
      // Circular search starting at the pointer.
      for (int unsigned k = 0; k < N; k++) begin
        pos = (32'(ptr_q) + k) % N;
        idx = W'(pos);
        if (!found && pend_q[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign load       = (!y_valid_q || bus.y_ready) && (pend_q != '0);
  assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;

  // Next-state: pending update, output register and round-robin pointer.
  always_comb begin
    pend_d    = pend_q | bus.w;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (load) begin
      // A fresh w[sel] in the load cycle re-arms the bit for a later issue.
      pend_d    = (pend_q & ~sel_onehot) | bus.w;
      y_d       = sel;
      y_valid_d = 1'b1;
      if (MODE != 0) begin
        ptr_d = (sel == W'(N - 1)) ? '0 : sel + 1'b1;
      end
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end
    if (MODE == 0) ptr_d = '0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (pend_q != '0) || y_valid_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: one fixed-priority and one round-robin instance, with
// expected issue order queued at stimulus time and popped as indices come out.
module tb_prio_encoder_q;

  logic clk;
  logic rst_n;

  prio_encoder_q_if #(.N(8), .W(3)) if0 ();
  prio_encoder_q_if #(.N(8), .W(3)) if1 ();

  prio_encoder_q #(.N(8), .W(3), .MODE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  prio_encoder_q #(.N(8), .W(3), .MODE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  int vectors;
  int miscompares;
  logic [2:0] sb[$];
  logic [2:0] exp_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns 1 time unit after a rising edge; inputs driven here are sampled next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.w = '0; if0.y_ready = 1'b1;
    if1.w = '0; if1.y_ready = 1'b1;
    #2;
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.y !== 3'd0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m0 y=%0d v=%0b busy=%0b exp y=0 v=0 busy=0",
               if0.y, if0.y_valid, if0.busy);
    end
    vectors++;
    if (if1.y_valid !== 1'b0 || if1.y !== 3'd0 || if1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m1 y=%0d v=%0b busy=%0b exp y=0 v=0 busy=0",
               if1.y, if1.y_valid, if1.busy);
    end
    // Requests while reset is held must be ignored.
    if0.w = 8'hFF;
    repeat (3) cycle();
    if0.w = '0;
    rst_n = 1'b1;
    repeat (3) cycle();
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ignore_w v=%0b busy=%0b exp v=0 busy=0", if0.y_valid, if0.busy);
    end
  endtask

  task automatic test_fixed();
    sb.push_back(3'd5);
    sb.push_back(3'd2);
    if0.y_ready = 1'b1;
    if0.w = 8'h24;
    cycle();
    if0.w = '0;
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_latency v=%0b busy=%0b exp v=0 busy=1", if0.y_valid, if0.busy);
    end
    repeat (2) begin
      cycle();
      exp_y = sb.pop_front();
      vectors++;
      if (if0.y_valid !== 1'b1 || if0.y !== exp_y) begin
        miscompares++;
        $display("FAIL fixed_seq y=%0d v=%0b exp y=%0d v=1", if0.y, if0.y_valid, exp_y);
      end
    end
    cycle();
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_idle v=%0b busy=%0b exp v=0 busy=0", if0.y_valid, if0.busy);
    end
  endtask

  task automatic test_backpressure();
    sb.push_back(3'd0);
    sb.push_back(3'd7);
    if0.y_ready = 1'b0;
    if0.w = 8'h01;
    cycle();
    if0.w = 8'h80;
    cycle();
    if0.w = '0;
    exp_y = sb.pop_front();
    repeat (3) begin
      vectors++;
      if (if0.y_valid !== 1'b1 || if0.y !== exp_y || if0.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold y=%0d v=%0b busy=%0b exp y=%0d v=1 busy=1",
                 if0.y, if0.y_valid, if0.busy, exp_y);
      end
      cycle();
    end
    if0.y_ready = 1'b1;
    cycle();
    exp_y = sb.pop_front();
    vectors++;
    if (if0.y_valid !== 1'b1 || if0.y !== exp_y) begin
      miscompares++;
      $display("FAIL bp_release y=%0d v=%0b exp y=%0d v=1", if0.y, if0.y_valid, exp_y);
    end
    cycle();
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle v=%0b busy=%0b exp v=0 busy=0", if0.y_valid, if0.busy);
    end
  endtask

  task automatic test_merge();
    // Bit 4 requested on two cycles while the output is stalled: issued once.
    sb.push_back(3'd0);
    sb.push_back(3'd4);
    if0.y_ready = 1'b0;
    if0.w = 8'h01;
    cycle();
    if0.w = 8'h10;
    cycle();
    cycle();
    if0.w = '0;
    if0.y_ready = 1'b1;
    repeat (2) begin
      exp_y = sb.pop_front();
      vectors++;
      if (if0.y_valid !== 1'b1 || if0.y !== exp_y) begin
        miscompares++;
        $display("FAIL merge_seq y=%0d v=%0b exp y=%0d v=1", if0.y, if0.y_valid, exp_y);
      end
      cycle();
    end
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL merge_once v=%0b busy=%0b exp v=0 busy=0", if0.y_valid, if0.busy);
    end
  endtask

  task automatic test_rerequest();
    sb.push_back(3'd3);
    sb.push_back(3'd3);
    if0.y_ready = 1'b1;
    if0.w = 8'h08;
    cycle();
    // Still asserted across the edge that loads index 3.
    cycle();
    if0.w = '0;
    repeat (2) begin
      exp_y = sb.pop_front();
      vectors++;
      if (if0.y_valid !== 1'b1 || if0.y !== exp_y) begin
        miscompares++;
        $display("FAIL rereq_seq y=%0d v=%0b exp y=%0d v=1", if0.y, if0.y_valid, exp_y);
      end
      cycle();
    end
    vectors++;
    if (if0.y_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rereq_idle v=%0b exp v=0", if0.y_valid);
    end
  endtask

  // Drives one request pattern into the round-robin instance and checks the issue order.
  task automatic rr_run(input logic [7:0] pattern, input int count, input string name);
    if1.y_ready = 1'b1;
    if1.w = pattern;
    cycle();
    if1.w = '0;
    repeat (count) begin
      cycle();
      exp_y = sb.pop_front();
      vectors++;
      if (if1.y_valid !== 1'b1 || if1.y !== exp_y) begin
        miscompares++;
        $display("FAIL %s y=%0d v=%0b exp y=%0d v=1", name, if1.y, if1.y_valid, exp_y);
      end
    end
    cycle();
    vectors++;
    if (if1.y_valid !== 1'b0 || if1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle v=%0b busy=%0b exp v=0 busy=0", name, if1.y_valid, if1.busy);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) sb.push_back(3'(i));
    rr_run(8'hFF, 8, "rr_all");
    // Pointer back at 0: index 0 goes before 7.
    sb.push_back(3'd0);
    sb.push_back(3'd7);
    rr_run(8'h81, 2, "rr_ptr0");
  endtask

  task automatic test_rr_wrap();
    sb.push_back(3'd6);
    rr_run(8'h40, 1, "rr_to6");
    // Pointer now 7: search wraps to 0 before reaching 6.
    sb.push_back(3'd0);
    sb.push_back(3'd6);
    rr_run(8'h41, 2, "rr_wrap");
  endtask

  task automatic test_reset_midop();
    if0.y_ready = 1'b0;
    if0.w = 8'h3C;
    cycle();
    cycle();
    if0.w = '0;
    vectors++;
    if (if0.y_valid !== 1'b1 || if0.y !== 3'd5) begin
      miscompares++;
      $display("FAIL midrst_pre y=%0d v=%0b exp y=5 v=1", if0.y, if0.y_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (if0.y !== 3'd0 || if0.y_valid !== 1'b0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async y=%0d v=%0b busy=%0b exp y=0 v=0 busy=0",
               if0.y, if0.y_valid, if0.busy);
    end
    cycle();
    rst_n = 1'b1;
    if0.y_ready = 1'b1;
    repeat (4) cycle();
    vectors++;
    if (if0.y_valid !== 1'b0 || if0.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_discard v=%0b busy=%0b exp v=0 busy=0", if0.y_valid, if0.busy);
    end
    // First request after release follows the normal two-edge latency.
    sb.push_back(3'd1);
    if0.w = 8'h02;
    cycle();
    if0.w = '0;
    cycle();
    exp_y = sb.pop_front();
    vectors++;
    if (if0.y_valid !== 1'b1 || if0.y !== exp_y) begin
      miscompares++;
      $display("FAIL midrst_first y=%0d v=%0b exp y=%0d v=1", if0.y, if0.y_valid, exp_y);
    end
    cycle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fixed();
    test_backpressure();
    test_merge();
    test_rerequest();
    test_round_robin();
    test_rr_wrap();
    test_reset_midop();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover size=%0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
